// File: rtl/output_arbiter.sv
// Round-robin share of the display datapath between the OUT-instruction and system-message paths.
// Latency: an accepted value appears on out_* one cycle after its valid/ready handshake.
// Backpressure: ready is withheld while a value is still inside its minimum hold time, during clear, and until the first clock after reset.
module output_arbiter #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 7,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 26,
    parameter bit STICKY      = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_write,
    output logic              grant_id,
    output logic              busy,
    output logic [15:0]       shown_count
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              rr_ptr, rr_ptr_nxt;
    logic              shown, shown_nxt;
    logic              armed;
    logic [DATA_W-1:0] data_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              write_nxt;
    logic              grant_nxt;
    logic [15:0]       count_nxt;
    logic              window;
    logic              sel;
    logic              xfer;

    // armed keeps ready low while reset is held without using reset as a data signal
    assign window     = armed && !clear && (state == IDLE || cnt == '0);
    assign sel        = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    assign req0_ready = window && req0_valid && !sel;
    assign req1_ready = window && req1_valid && sel;
    assign xfer       = req0_ready || req1_ready;
    assign busy       = (state == HOLD);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rr_ptr_nxt = rr_ptr;
        shown_nxt  = shown;
        data_nxt   = out_data;
        addr_nxt   = out_addr;
        write_nxt  = out_write;
        grant_nxt  = grant_id;
        count_nxt  = shown_count;
        if (clear) begin
            state_nxt = IDLE;
            write_nxt = 1'b0;
            shown_nxt = 1'b0;
            cnt_nxt   = '0;
        end else if (xfer) begin
            data_nxt   = sel ? req1_data : req0_data;
            addr_nxt   = sel ? req1_addr : req0_addr;
            write_nxt  = 1'b1;
            grant_nxt  = sel;
            rr_ptr_nxt = ~sel;
            cnt_nxt    = HOLD_RELOAD;
            state_nxt  = HOLD;
            shown_nxt  = 1'b1;
            count_nxt  = shown_count + 16'd1;
        end else if (state == HOLD) begin
            if (cnt != '0) begin
                cnt_nxt = cnt - CNT_W'(1);
            end else begin
                state_nxt = IDLE;
                write_nxt = STICKY & shown;
            end
        end else begin
            write_nxt = STICKY & shown;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rr_ptr      <= 1'b0;
            shown       <= 1'b0;
            armed       <= 1'b0;
            out_data    <= '0;
            out_addr    <= '0;
            out_write   <= 1'b0;
            grant_id    <= 1'b0;
            shown_count <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rr_ptr      <= rr_ptr_nxt;
            shown       <= shown_nxt;
            armed       <= 1'b1;
            out_data    <= data_nxt;
            out_addr    <= addr_nxt;
            out_write   <= write_nxt;
            grant_id    <= grant_nxt;
            shown_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_output_arbiter.sv
// Bench for output_arbiter: instance a (HOLD_CYCLES=4, STICKY=0) is scoreboarded,
// instance b (HOLD_CYCLES=1, STICKY=1) covers sticky display, clear, counter wrap and async reset.
module tb_output_arbiter;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic [6:0]  addr;
        logic        grant;
    } exp_t;
    exp_t sb[$];

    // instance a signals
    logic        a_rst, a_clear, a_v0, a_v1, a_r0, a_r1;
    logic [31:0] a_d0, a_d1, a_out_data;
    logic [6:0]  a_a0, a_a1, a_out_addr;
    logic        a_write, a_grant, a_busy;
    logic [15:0] a_count;

    // instance b signals
    logic        b_rst, b_clear, b_v0, b_v1, b_r0, b_r1;
    logic [31:0] b_d0, b_d1, b_out_data;
    logic [6:0]  b_a0, b_a1, b_out_addr;
    logic        b_write, b_grant, b_busy;
    logic [15:0] b_count;

    output_arbiter #(.DATA_W(32), .ADDR_W(7), .HOLD_CYCLES(4), .CNT_W(26), .STICKY(1'b0)) dut_a (
        .clk(clk), .reset(a_rst), .clear(a_clear),
        .req0_valid(a_v0), .req0_data(a_d0), .req0_addr(a_a0), .req0_ready(a_r0),
        .req1_valid(a_v1), .req1_data(a_d1), .req1_addr(a_a1), .req1_ready(a_r1),
        .out_data(a_out_data), .out_addr(a_out_addr), .out_write(a_write),
        .grant_id(a_grant), .busy(a_busy), .shown_count(a_count)
    );

    output_arbiter #(.DATA_W(32), .ADDR_W(7), .HOLD_CYCLES(1), .CNT_W(26), .STICKY(1'b1)) dut_b (
        .clk(clk), .reset(b_rst), .clear(b_clear),
        .req0_valid(b_v0), .req0_data(b_d0), .req0_addr(b_a0), .req0_ready(b_r0),
        .req1_valid(b_v1), .req1_data(b_d1), .req1_addr(b_a1), .req1_ready(b_r1),
        .out_data(b_out_data), .out_addr(b_out_addr), .out_write(b_write),
        .grant_id(b_grant), .busy(b_busy), .shown_count(b_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [6:0] a, input logic g);
        exp_t e;
        e.data  = d;
        e.addr  = a;
        e.grant = g;
        sb.push_back(e);
    endtask

    // Monitor: each new accepted value on instance a is matched against the scoreboard
    logic [15:0] mon_prev = 16'd0;
    always @(negedge clk) begin
        if (!a_rst) begin
            mon_prev = 16'd0;
        end else if (a_count != mon_prev) begin
            mon_prev = a_count;
            if (sb.size() == 0) begin
                chk("sb_unexpected_value", a_out_data, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_data", a_out_data, e.data);
                chk("sb_addr", {25'd0, a_out_addr}, {25'd0, e.addr});
                chk("sb_grant", {31'd0, a_grant}, {31'd0, e.grant});
                chk("sb_write", {31'd0, a_write}, 32'd1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst = 1'b0; a_clear = 1'b0;
        a_v0 = 1'b1; a_d0 = 32'h0000_002A; a_a0 = 7'd5;
        a_v1 = 1'b0; a_d1 = 32'd0; a_a1 = 7'd0;
        b_rst = 1'b0; b_clear = 1'b0;
        b_v0 = 1'b0; b_d0 = 32'd0; b_a0 = 7'd0;
        b_v1 = 1'b0; b_d1 = 32'd0; b_a1 = 7'd0;

        // reset held with req0 valid: everything zero, no ready
        repeat (3) @(negedge clk);
        chk("rst_out_data", a_out_data, 32'd0);
        chk("rst_out_addr", {25'd0, a_out_addr}, 32'd0);
        chk("rst_write", {31'd0, a_write}, 32'd0);
        chk("rst_grant", {31'd0, a_grant}, 32'd0);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_count", {16'd0, a_count}, 32'd0);
        chk("rst_ready0", {31'd0, a_r0}, 32'd0);
        a_rst = 1'b1;
        b_rst = 1'b1;

        // single value, displayed exactly 4 cycles then blanked
        @(negedge clk); #1;
        chk("single_ready0", {31'd0, a_r0}, 32'd1);
        push(32'h0000_002A, 7'd5, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            a_v0 = 1'b0;
            #1;
            chk($sformatf("single_write_t%0d", k), {31'd0, a_write}, (k <= 4) ? 32'd1 : 32'd0);
            chk($sformatf("single_busy_t%0d", k), {31'd0, a_busy}, (k <= 4) ? 32'd1 : 32'd0);
        end
        chk("single_data_kept", a_out_data, 32'h0000_002A);
        chk("single_count", {16'd0, a_count}, 32'd1);

        // req1 arrives mid-hold of a req0 value and waits for the window
        @(negedge clk);
        a_v0 = 1'b1; a_d0 = 32'h33; a_a0 = 7'd1;
        #1;
        chk("held_ready0", {31'd0, a_r0}, 32'd1);
        push(32'h33, 7'd1, 1'b0);
        push(32'h44, 7'd2, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            a_v0 = 1'b0;
            a_v1 = 1'b1; a_d1 = 32'h44; a_a1 = 7'd2;
            #1;
            chk($sformatf("held_ready1_t%0d", k), {31'd0, a_r1}, (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("held_data_t%0d", k), a_out_data, 32'h33);
        end
        @(negedge clk);
        a_v1 = 1'b0;
        #1;
        chk("held_next_data", a_out_data, 32'h44);
        chk("held_next_write", {31'd0, a_write}, 32'd1);
        repeat (4) @(negedge clk);
        #1;
        chk("held_idle_busy", {31'd0, a_busy}, 32'd0);

        // contention: strict alternation with no blank cycle
        @(negedge clk);
        a_v0 = 1'b1; a_d0 = 32'h11; a_a0 = 7'd3;
        a_v1 = 1'b1; a_d1 = 32'h22; a_a1 = 7'd4;
        push(32'h11, 7'd3, 1'b0);
        push(32'h22, 7'd4, 1'b1);
        push(32'h11, 7'd3, 1'b0);
        push(32'h22, 7'd4, 1'b1);
        #1;
        chk("cont_ready0_t0", {31'd0, a_r0}, 32'd1);
        chk("cont_ready1_t0", {31'd0, a_r1}, 32'd0);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 13) begin
                a_v0 = 1'b0;
                a_v1 = 1'b0;
            end
            #1;
            chk($sformatf("cont_write_t%0d", k), {31'd0, a_write}, (k <= 16) ? 32'd1 : 32'd0);
            if (k <= 16)
                chk($sformatf("cont_grant_t%0d", k), {31'd0, a_grant}, ((k - 1) / 4) % 2);
            if (k <= 12) begin
                chk($sformatf("cont_ready0_t%0d", k), {31'd0, a_r0}, (k == 8) ? 32'd1 : 32'd0);
                chk($sformatf("cont_ready1_t%0d", k), {31'd0, a_r1}, (k == 4 || k == 12) ? 32'd1 : 32'd0);
            end
        end
        chk("a_final_count", {16'd0, a_count}, 32'd7);

        // instance b: sticky display, clear priority
        @(negedge clk);
        b_v0 = 1'b1; b_d0 = 32'h7; b_a0 = 7'd9;
        #1;
        chk("sticky_ready0", {31'd0, b_r0}, 32'd1);
        @(negedge clk);
        b_v0 = 1'b0;
        #1;
        chk("sticky_data", b_out_data, 32'h7);
        chk("sticky_hold_write", {31'd0, b_write}, 32'd1);
        chk("sticky_hold_busy", {31'd0, b_busy}, 32'd1);
        @(negedge clk); #1;
        chk("sticky_idle_write", {31'd0, b_write}, 32'd1);
        chk("sticky_idle_busy", {31'd0, b_busy}, 32'd0);
        @(negedge clk);
        b_clear = 1'b1; b_v0 = 1'b1; b_d0 = 32'h8;
        #1;
        chk("clear_blocks_ready0", {31'd0, b_r0}, 32'd0);
        @(negedge clk);
        b_clear = 1'b0; b_v0 = 1'b0;
        #1;
        chk("clear_write", {31'd0, b_write}, 32'd0);
        chk("clear_data_kept", b_out_data, 32'h7);
        chk("clear_count_kept", {16'd0, b_count}, 32'd1);

        // back-to-back single-cycle holds up to and past the counter wrap
        @(negedge clk);
        b_v0 = 1'b1; b_d0 = 32'hABC; b_a0 = 7'd3;
        repeat (65534) @(negedge clk);
        #1;
        chk("wrap_count_max", {16'd0, b_count}, 32'h0000_FFFF);
        @(negedge clk);
        b_v0 = 1'b0;
        #1;
        chk("wrap_count_zero", {16'd0, b_count}, 32'd0);
        chk("wrap_write", {31'd0, b_write}, 32'd1);
        chk("wrap_busy", {31'd0, b_busy}, 32'd1);

        // reset mid-hold takes effect between clock edges
        #1;
        b_rst = 1'b0;
        #1;
        chk("async_rst_write", {31'd0, b_write}, 32'd0);
        chk("async_rst_busy", {31'd0, b_busy}, 32'd0);
        chk("async_rst_data", b_out_data, 32'd0);

        @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_arbiter.md
Name: output_arbiter

Overview:
- Shares the single output display datapath between two requesters: req0 is the processor OUT instruction path, req1 is the system/monitor message path.
- Drives the display block's data, address and write inputs.
- The display blanks its four value digits whenever write is low, so this block holds write high for a guaranteed minimum on-screen time per accepted value.
- Arbitration is round-robin with valid/ready handshakes. Sits between the control unit and the output display block.

Parameters:
- DATA_W, 32, width of the displayed value.
- ADDR_W, 7, width of the output address.
- HOLD_CYCLES, 4, minimum number of cycles each accepted value is displayed. Legal range is 1 to 2^CNT_W-1.
- CNT_W, 26, width of the hold counter.
- STICKY, 1. When 1, the last value stays displayed after its hold expires. When 0, the display blanks after the hold expires.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous pulse: blank the display and abandon the current hold.
- req0_valid  input  1  processor has a value to show.
- req0_data  input  DATA_W  processor value.
- req0_addr  input  ADDR_W  processor output address.
- req0_ready  output  1  processor value accepted this cycle.
- req1_valid  input  1  system path has a value to show.
- req1_data  input  DATA_W  system value.
- req1_addr  input  ADDR_W  system output address.
- req1_ready  output  1  system value accepted this cycle.
- out_data  output  DATA_W  value to display (registered).
- out_addr  output  ADDR_W  address to display (registered).
- out_write  output  1  display-enable to the output block (registered).
- grant_id  output  1  requester owning the current or last shown value.
- busy  output  1  high while in HOLD.
- shown_count  output  16  number of accepted transfers; wraps at 0xFFFF to 0.

Behaviour:
Reset (reset=0, asynchronous) sets the following; all are held while reset is low:
- state=IDLE, out_data=0, out_addr=0, out_write=0, grant_id=0.
- rr_ptr=0, cnt=0, shown_count=0, shown=0.

States: IDLE and HOLD.

Accept window:
- Open when state==IDLE, or when state==HOLD and cnt==0, and clear==0.

Arbitration (combinational):
- Only one valid: that requester is selected.
- Both valid: requester rr_ptr is selected.
- readyX=1 only for the selected requester, only while its valid is high, only inside the accept window.
- A transfer occurs when valid&ready are both high.
- readyX never depends on the other requester's ready.

On a transfer from requester i, at the next posedge:
- out_data and out_addr load the requester's data and address.
- out_write=1, grant_id=i, rr_ptr=~i.
- cnt=HOLD_CYCLES-1, state=HOLD, shown=1, shown_count+=1.
- Latency: value visible on out_* exactly 1 cycle after the handshake cycle.

HOLD:
- out_write stays 1. out_data and out_addr are stable. Requester data changes are ignored.
- cnt decrements each cycle while nonzero.
- At cnt==0 with a transfer: reload as above. Back-to-back values give no blank cycle.
- At cnt==0 with no valid: go to IDLE. out_write becomes STICKY&shown. out_data is retained.
- HOLD_CYCLES=1: every accepted value is displayed for exactly 1 cycle before the window reopens.

IDLE:
- out_write = STICKY&shown.
- busy=0.

clear=1 (any state) has priority over everything except reset. Next posedge:
- state=IDLE, out_write=0, shown=0, cnt=0.
- out_data and out_addr are retained. rr_ptr and shown_count are unchanged.
- No ready is asserted in a cycle where clear=1.

Simultaneous events:
- Requester valid may deassert before ready without penalty; no transfer occurs.
- Data must be held stable while valid is high and ready is low.

Reset mid-HOLD aborts immediately. out_write drops asynchronously.

Test Plan:
- Reset: reset=0 with req0_valid=1 -> all outputs 0, no ready. Release reset; next cycle req0_ready=1. One cycle after the handshake: out_data=req0_data, out_write=1.
- Single value, HOLD_CYCLES=4, STICKY=0: req0 sends 0x0000002A at cycle t -> out_write high t+1..t+4, low at t+5; shown_count=1; busy low at t+5.
- Contention: both valid continuously with data 0x11 (req0) and 0x22 (req1) -> order 0x11, 0x22, 0x11, 0x22. Each is shown 4 cycles with no blank gap; grant_id alternates 0,1,0,1.
- Held-off requester: req1 asserts valid mid-HOLD of a req0 value -> req1_ready stays 0 until cnt==0, then is asserted. out_data unchanged during the hold.
- STICKY=1 and clear: show 0x7 -> after hold, out_write stays 1 in IDLE. Pulse clear -> out_write=0 next cycle and out_data stays 0x7. clear asserted together with req0_valid -> req0_ready=0.
- Wrap and async reset: preload 65535 transfers (HOLD_CYCLES=1) -> shown_count wraps to 0. Assert reset mid-HOLD -> out_write drops without waiting for a clk edge.
